// File: rtl/lane_change_pkg.sv
// Shared types and default sizing for the lane change collector.
package lane_change_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SEQ_WIDTH  = 8;
  localparam int unsigned IDX_WIDTH  = (LANES > 1) ? $clog2(LANES) : 1;

  // Field widths are fixed here; change LANES/SEQ_WIDTH together with the top overrides.
  typedef struct packed {
    logic [IDX_WIDTH-1:0] lane;
    logic                 value;
    logic [SEQ_WIDTH-1:0] seq;
  } event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous DEPTH-entry FIFO of event_t; head reads as zero while empty.
module event_fifo
  import lane_change_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  event_t                 din,
  input  logic                   pop,
  output event_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  event_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/lane_change_collector.sv
// Detects per-lane value changes and serialises them, round-robin, into an
// ordered event stream of {lane, new value, sequence number}.
module lane_change_collector
  import lane_change_pkg::*;
#(
  parameter  int unsigned N     = LANES,
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  parameter  int unsigned SEQW  = SEQ_WIDTH,
  localparam int unsigned IDXW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           lane_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDXW-1:0]        out_lane,
  output logic                   out_value,
  output logic [SEQW-1:0]        out_seq,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic [N-1:0]    lane_prev;
  logic [N-1:0]    pending;
  logic [N-1:0]    pend_val;
  logic [N-1:0]    changed;
  logic [N-1:0]    grant_mask;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] grant_idx;
  logic [SEQW-1:0] seq;
  logic            grant_any;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  event_t          push_ev;
  event_t          head_ev;
  int unsigned     cand;

  assign changed = lane_in ^ lane_prev;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(rr_ptr) + k) % N;
      if (!grant_any && pending[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDXW'(cand);
      end
    end
  end

  assign pop        = out_valid && out_ready;
  assign push       = grant_any && (!full || pop);
  assign grant_mask = push ? (N'(1) << grant_idx) : '0;

  always_comb begin
    push_ev       = '0;
    push_ev.lane  = grant_idx;
    push_ev.value = pend_val[grant_idx];
    push_ev.seq   = seq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_prev <= lane_in;
      pending   <= '0;
      pend_val  <= '0;
      rr_ptr    <= '0;
      seq       <= '0;
    end else begin
      lane_prev <= lane_in;
      // Clearing the grant before OR-ing in changes keeps a same-edge change pending.
      pending   <= (pending & ~grant_mask) | changed;
      pend_val  <= (pend_val & ~changed) | (lane_in & changed);
      if (push) begin
        seq    <= seq + SEQW'(1);
        rr_ptr <= (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + IDXW'(1);
      end
    end
  end

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_ev),
    .pop   (pop),
    .dout  (head_ev),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out_valid = !empty;
  assign out_lane  = head_ev.lane;
  assign out_value = head_ev.value;
  assign out_seq   = head_ev.seq;

endmodule

// File: tb/tb_lane_change_collector.sv
// Bench for lane_change_collector: event-queue reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_lane_change_collector;

  localparam int NL = 4;
  localparam int DP = 4;

  logic       clk;
  logic       rst;
  logic [3:0] lane_in;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_lane;
  logic       out_value;
  logic [7:0] out_seq;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;

  lane_change_collector #(
    .N     (4),
    .DEPTH (4),
    .SEQW  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lane_in    (lane_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lane   (out_lane),
    .out_value  (out_value),
    .out_seq    (out_seq),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events waiting per lane, an ordered queue of emitted events.
  bit armed = 0;
  bit m_prev [NL];
  bit m_pend [NL];
  bit m_pval [NL];
  int m_rr;
  int m_seq;
  int q_lane[$];
  int q_val[$];
  int q_seq[$];

  always @(posedge clk) begin : model
    int  g;
    int  c;
    bit  pop_now;
    bit  room;
    if (rst) begin
      armed = 1;
      q_lane.delete();
      q_val.delete();
      q_seq.delete();
      m_rr  = 0;
      m_seq = 0;
      for (int i = 0; i < NL; i++) begin
        m_prev[i] = lane_in[i];
        m_pend[i] = 0;
        m_pval[i] = 0;
      end
    end else if (armed) begin
      pop_now = (q_lane.size() > 0) && out_ready;
      room    = (q_lane.size() < DP) || pop_now;
      g = -1;
      for (int off = 0; off < NL; off++) begin
        c = (m_rr + off) % NL;
        if (g < 0 && m_pend[c]) g = c;
      end
      if (pop_now) begin
        void'(q_lane.pop_front());
        void'(q_val.pop_front());
        void'(q_seq.pop_front());
      end
      if (g >= 0 && room) begin
        q_lane.push_back(g);
        q_val.push_back(int'(m_pval[g]));
        q_seq.push_back(m_seq);
        m_pend[g] = 0;
        m_seq = (m_seq + 1) % 256;
        m_rr  = (g + 1) % NL;
      end
      for (int i = 0; i < NL; i++) begin
        if (lane_in[i] != m_prev[i]) begin
          m_pend[i] = 1;
          m_pval[i] = lane_in[i];
        end
        m_prev[i] = lane_in[i];
      end
    end
  end

  always @(negedge clk) begin : compare
    if (armed) begin
      check("model_valid", int'(out_valid), int'(q_lane.size() != 0));
      check("model_count", int'(fifo_count), q_lane.size());
      check("model_lane",  int'(out_lane),  (q_lane.size() != 0) ? q_lane[0] : 0);
      check("model_value", int'(out_value), (q_lane.size() != 0) ? q_val[0]  : 0);
      check("model_seq",   int'(out_seq),   (q_lane.size() != 0) ? q_seq[0]  : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    rst       = 1'b1;
    lane_in   = 4'b0000;
    out_ready = rdy;
    tick();
    rst = 1'b0;
  endtask

  int n3;
  int v3;
  int s3;
  logic [3:0] flip;

  initial begin
    // Reset-quiet: lanes already set at reset produce nothing.
    rst       = 1'b1;
    lane_in   = 4'b1010;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("quiet_valid", int'(out_valid), 0);
    end

    // Single change on lane 2: two-cycle latency.
    do_reset(1'b1);
    lane_in = 4'b0100;
    tick();
    check("single_e0_valid", int'(out_valid), 0);
    tick();
    check("single_valid", int'(out_valid), 1);
    check("single_lane",  int'(out_lane),  2);
    check("single_value", int'(out_value), 1);
    check("single_seq",   int'(out_seq),   0);
    tick();
    check("single_count_after_pop", int'(fifo_count), 0);

    // All four lanes change together.
    do_reset(1'b1);
    lane_in = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("simul_lane",  int'(out_lane),  k);
      check("simul_seq",   int'(out_seq),   k);
      check("simul_value", int'(out_value), 1);
    end
    lane_in = 4'b0000;
    tick();
    tick();
    check("simul_rr_wrap_lane", int'(out_lane), 0);
    check("simul_rr_wrap_seq",  int'(out_seq),  4);
    repeat (4) tick();

    // Backpressure until full, then drain.
    do_reset(1'b0);
    lane_in = 4'b1111;
    tick();
    tick();
    lane_in = 4'b1110;
    repeat (4) tick();
    check("bp_count", int'(fifo_count), 4);
    check("bp_valid", int'(out_valid), 1);
    check("bp_head_lane", int'(out_lane), 0);
    check("bp_head_seq",  int'(out_seq),  0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_drain_lane",  int'(out_lane),  (k == 4) ? 0 : k);
      check("bp_drain_seq",   int'(out_seq),   k);
      check("bp_drain_value", int'(out_value), (k == 4) ? 0 : 1);
      tick();
    end
    check("bp_empty", int'(fifo_count), 0);

    // Lane 3 toggles twice while the FIFO is full: one event, latest value.
    do_reset(1'b0);
    lane_in = 4'b0111;
    repeat (4) tick();
    lane_in = 4'b0110;
    repeat (2) tick();
    check("coal_full", int'(fifo_count), 4);
    lane_in = 4'b1110;
    tick();
    lane_in = 4'b0110;
    tick();
    out_ready = 1'b1;
    n3 = 0;
    v3 = -1;
    s3 = -1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid && out_lane == 2'd3) begin
        n3++;
        v3 = int'(out_value);
        s3 = int'(out_seq);
      end
      tick();
    end
    check("coal_lane3_events", n3, 1);
    check("coal_lane3_value",  v3, 0);
    check("coal_lane3_seq",    s3, 4);

    // Reset with events queued and pending.
    do_reset(1'b0);
    lane_in = 4'b0111;
    repeat (4) tick();
    lane_in = 4'b0001;
    tick();
    check("midrst_count_before", int'(fifo_count), 3);
    rst = 1'b1;
    tick();
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_count", int'(fifo_count), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("midrst_quiet", int'(out_valid), 0);
    lane_in = 4'b0011;
    tick();
    tick();
    check("midrst_next_valid", int'(out_valid), 1);
    check("midrst_next_lane",  int'(out_lane),  1);
    check("midrst_next_seq",   int'(out_seq),   0);

    // Randomised traffic, occasional reset, checked by the model every cycle.
    do_reset(1'b1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NL; i++) flip[i] = ($urandom_range(0, 3) == 0);
      lane_in   = lane_in ^ flip;
      out_ready = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
